// File: rtl/mem_arbiter.sv
// Serializes instruction-fetch reads and data loads/stores onto one synchronous SRAM port.
// Data wins ties; after D_MAX consecutive data grants with fetch waiting, fetch is granted.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LAT    = 1,
  parameter int unsigned D_MAX  = 4
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DCNT_W = $clog2(D_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                fetch_win;
  logic                i_ack_d, d_ack_d, mem_en_d, mem_we_d, busy_d, owner_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, i_rdata_d, d_rdata_d;

  // State and all outputs are registered together.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wcnt_q    <= '0;
      dcnt_q    <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wcnt_q    <= wcnt_d;
      dcnt_q    <= dcnt_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
      owner     <= owner_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    owner_d     = owner;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    fetch_win   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          fetch_win = i_req && (!d_req || (dcnt_q == DCNT_W'(D_MAX)));
          owner_d   = !fetch_win;
          if (fetch_win) begin
            mem_addr_d = i_addr;
            we_d       = 1'b0;
            dcnt_d     = '0;
          end else begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
            if (!i_req) begin
              dcnt_d = '0;
            end else if (dcnt_q != DCNT_W'(D_MAX)) begin
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = CNT_W'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q - CNT_W'(1);
        // Last wait cycle: read data is on mem_rdata now.
        if (wcnt_q == CNT_W'(1)) begin
          if (!owner) begin
            i_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          i_ack_d = !owner;
          d_ack_d = owner;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
